eth_phy_10g_tx_hdr_err_inj: RTL

ETH_PHY_10G_TX_HDR_ERR_INJ -- requirements
Module: eth_phy_10g_tx_hdr_err_inj

---
 rtl/eth_phy_10g_tx_hdr_err_inj_pkg.sv | 20 ++
 rtl/eth_phy_10g_win_timer.sv | 30 +++
 rtl/eth_phy_10g_tx_hdr_err_inj.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/eth_phy_10g_tx_hdr_err_inj_pkg.sv
// Shared 10GBASE-R PCS constants: sync header codes and the two invalid headers
// used by the TX error injector and the RX BER monitor.
package eth_phy_10g_tx_hdr_err_inj_pkg;

    localparam logic [1:0] SYNC_DATA  = 2'b10;
    localparam logic [1:0] SYNC_CTRL  = 2'b01;
    localparam logic [1:0] INV_HDR_00 = 2'b00;
    localparam logic [1:0] INV_HDR_11 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_HOLD   = 2'd2
    } inj_state_e;

    function automatic logic [1:0] inv_hdr(input logic pattern);
        return pattern ? INV_HDR_11 : INV_HDR_00;
    endfunction

endpackage

// File: rtl/eth_phy_10g_win_timer.sv
// Free-running window down-counter; tick marks the window-start (zero) cycle.
// Period is COUNT_125US+1 cycles.
module eth_phy_10g_win_timer #(
    parameter int COUNT_125US = 125000/10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (COUNT_125US > 0) ? $clog2(COUNT_125US + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(COUNT_125US);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == '0);
        count_d = tick ? LOAD : count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/eth_phy_10g_tx_hdr_err_inj.sv
// TX sync-header error injector: forces invalid headers at a configured rate
// per window so the far-end BER monitor can be exercised.
//   state     | meaning
//   ST_IDLE   | no injection this window (disabled or count 0)
//   ST_INJECT | injections pending in the current window
//   ST_HOLD   | all injections for this window done, pass-through
module eth_phy_10g_tx_hdr_err_inj
    import eth_phy_10g_tx_hdr_err_inj_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int COUNT_125US = 125000/10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    input  logic                  cfg_inj_enable,
    input  logic [4:0]            cfg_inj_count,
    input  logic [7:0]            cfg_inj_spacing,
    input  logic                  cfg_inj_pattern,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    output logic                  stat_inj_active,
    output logic                  stat_window_done,
    output logic [15:0]           stat_inj_total
);

    generate
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_10g_tx_hdr_err_inj: HDR_WIDTH must be 2");
        end
    endgenerate

    logic                  tick;
    inj_state_e            state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [7:0]            spacing_q, spacing_d;
    logic                  pattern_q, pattern_d;
    logic [4:0]            done_q, done_d;
    logic [7:0]            gap_q, gap_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                  win_done_q, win_done_d;
    logic [15:0]           total_q, total_d;
    logic                  inject;
    logic [1:0]            inj_hdr;

    eth_phy_10g_win_timer #(
        .COUNT_125US (COUNT_125US)
    ) u_win_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        spacing_d  = spacing_q;
        pattern_d  = pattern_q;
        done_d     = done_q;
        gap_d      = gap_q;
        data_d     = encoded_tx_data;
        hdr_d      = encoded_tx_hdr;
        win_done_d = tick;
        total_d    = total_q;
        inject     = 1'b0;
        inj_hdr    = inv_hdr(pattern_q);

        if (tick) begin
            cnt_d     = cfg_inj_count;
            spacing_d = cfg_inj_spacing;
            pattern_d = cfg_inj_pattern;
        end

        // The window-start word is itself the first injection, so it uses the
        // config being latched this cycle rather than the stale registers.
        if (!cfg_inj_enable) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            if (cfg_inj_count != 5'd0) begin
                inject  = 1'b1;
                inj_hdr = inv_hdr(cfg_inj_pattern);
                done_d  = 5'd1;
                gap_d   = cfg_inj_spacing;
                state_d = (cfg_inj_count == 5'd1) ? ST_HOLD : ST_INJECT;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_INJECT) begin
            if (gap_q == 8'd0) begin
                inject = 1'b1;
                done_d = done_q + 5'd1;
                gap_d  = spacing_q;
                if (done_q + 5'd1 == cnt_q) begin
                    state_d = ST_HOLD;
                end
            end else begin
                gap_d = gap_q - 8'd1;
            end
        end

        if (inject) begin
            hdr_d = HDR_WIDTH'(inj_hdr);
            if (total_q != 16'hFFFF) begin
                total_d = total_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            spacing_q  <= '0;
            pattern_q  <= 1'b0;
            done_q     <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            hdr_q      <= HDR_WIDTH'(SYNC_DATA);
            win_done_q <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            spacing_q  <= spacing_d;
            pattern_q  <= pattern_d;
            done_q     <= done_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            hdr_q      <= hdr_d;
            win_done_q <= win_done_d;
            total_q    <= total_d;
        end
    end

    assign serdes_tx_data   = data_q;
    assign serdes_tx_hdr    = hdr_q;
    assign stat_inj_active  = (state_q == ST_INJECT);
    assign stat_window_done = win_done_q;
    assign stat_inj_total   = total_q;

endmodule
